sine_addr_gen: RTL and testbench

Phase-accumulator address generator that sits directly upstream of the sine lookup table. It produces the signed 32-bit address stream (range 0..ADDR_MAX-1, one sine period) that the LUT converts into sine samples. Output frequency is set by a programmable step. Runs for a fixed sample count or continuously, with a valid/ready handshake so downstream stages can stall it.

---
 rtl/sine_addr_gen_if.sv | 21 ++
 rtl/sine_addr_gen.sv | 133 +++++++++++++
 tb/tb_sine_addr_gen.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sine_addr_gen_if.sv
// Address stream handshake between the phase accumulator and the sine LUT.
interface sine_addr_gen_if;
    logic signed [31:0] address;
    logic               addr_valid;
    logic               addr_ready;
    logic               wrap;

    modport master (
        output address,
        output addr_valid,
        output wrap,
        input  addr_ready
    );

    modport slave (
        input  address,
        input  addr_valid,
        input  wrap,
        output addr_ready
    );
endinterface

// File: rtl/sine_addr_gen.sv
// Phase-accumulator address generator feeding the sine LUT.
// Emits addresses modulo ADDR_MAX for a fixed sample count or continuously, with a valid/ready handshake.
module sine_addr_gen #(
    parameter int unsigned ADDR_MAX = 300,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [15:0]      step,
    input  logic [CNT_W-1:0] num_samples,
    output logic             busy,
    output logic             done,
    sine_addr_gen_if.master  bus
);

    localparam int unsigned STEP_W = 16;
    localparam int unsigned ADDR_W = (ADDR_MAX > 1) ? $clog2(ADDR_MAX) : 1;
    localparam int unsigned SUM_W  = ((ADDR_W > STEP_W) ? ADDR_W : STEP_W) + 1;

    localparam logic [SUM_W-1:0] ADDR_MAX_S  = SUM_W'(ADDR_MAX);
    localparam logic [SUM_W-1:0] ADDR_LAST_S = SUM_W'(ADDR_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [SUM_W-1:0]   step_q;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic               wrap_q;

    logic [SUM_W-1:0]   step_ext;
    logic [SUM_W-1:0]   step_d;
    logic [SUM_W-1:0]   sum_d;
    logic               wrap_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               xfer;
    logic               last_xfer;

    // Both operands stay below ADDR_MAX, so a single conditional subtract keeps the sum in range.
    always_comb begin
        step_ext  = SUM_W'(step);
        step_d    = (step_ext >= ADDR_MAX_S) ? ADDR_LAST_S : step_ext;
        sum_d     = SUM_W'(addr_q) + step_q;
        wrap_d    = (sum_d >= ADDR_MAX_S);
        addr_d    = wrap_d ? ADDR_W'(sum_d - ADDR_MAX_S) : ADDR_W'(sum_d);
        cnt_d     = cnt_q + CNT_W'(1);
        xfer      = valid_q && bus.addr_ready;
        last_xfer = (num_q != '0) && (cnt_d == num_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            step_q  <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (start && !stop) begin
                        step_q  <= step_d;
                        num_q   <= num_samples;
                        addr_q  <= '0;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end

                // A transfer in the stop cycle is counted but the address is frozen.
                ST_RUN: begin
                    if (xfer) begin
                        cnt_q <= cnt_d;
                    end
                    if (stop) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (xfer) begin
                        if (last_xfer) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            addr_q <= addr_d;
                            wrap_q <= wrap_d;
                        end
                    end
                end

                ST_DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.address    = $signed(32'(addr_q));
    assign bus.addr_valid = valid_q;
    assign bus.wrap       = wrap_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_sine_addr_gen.sv
// Randomized scoreboard bench for sine_addr_gen: driver queues expected addresses, monitor checks transfers.
module tb_sine_addr_gen;

    localparam int unsigned AM = 300;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [15:0]   step;
    logic [CW-1:0] num_samples;
    logic          busy;
    logic          done;

    sine_addr_gen_if bus ();

    sine_addr_gen #(.ADDR_MAX(AM), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .step        (step),
        .num_samples (num_samples),
        .busy        (busy),
        .done        (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        bit          wrap;
        bit          last;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;
    int   pend  = 0;
    int unsigned last_pop_addr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: k-th address is (k*step) mod ADDR_MAX; a wrap occurs whenever the period index advances.
    task automatic push_run(input int unsigned s, input int unsigned n, input bit finite);
        exp_t e;
        for (int unsigned k = 0; k < n; k++) begin
            longint unsigned ph = longint'(k) * s;
            e.addr = int'(ph % AM);
            e.wrap = (k > 0) && ((ph / AM) != ((ph - s) / AM));
            e.last = finite && (k == n - 1);
            q.push_back(e);
        end
    endtask

    function automatic int unsigned eff_step(input int unsigned s);
        return (s >= AM) ? AM - 1 : s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: checks every presented address against the queue head and tracks done/busy after the final transfer.
    initial begin
        bit prev_valid = 0;
        bit prev_xfer  = 0;
        bit xfer;
        bit first;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 0;
                prev_xfer  = 0;
                pend       = 0;
                continue;
            end
            if (pend == 1) begin
                chk("done_pulse", 64'(done), 64'(1));
                chk("busy_in_done", 64'(busy), 64'(1));
                chk("valid_in_done", 64'(bus.addr_valid), 64'(0));
                pend = 2;
            end else if (pend == 2) begin
                chk("done_clear", 64'(done), 64'(0));
                chk("busy_after_done", 64'(busy), 64'(0));
                pend = 0;
            end else if (done) begin
                chk("spurious_done", 64'(done), 64'(0));
            end
            xfer = 0;
            if (bus.addr_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got address %0d with nothing expected", bus.address);
                end else begin
                    first = !prev_valid || prev_xfer;
                    chk("address", 64'(bus.address), 64'(q[0].addr));
                    chk("wrap", 64'(bus.wrap), first ? 64'(q[0].wrap) : 64'(0));
                    if (bus.addr_ready) begin
                        xfer = 1;
                        e = q.pop_front();
                        pops++;
                        last_pop_addr = e.addr;
                        if (e.last) pend = 1;
                    end
                end
            end else if (bus.wrap) begin
                chk("wrap_while_idle", 64'(bus.wrap), 64'(0));
            end
            prev_valid = bus.addr_valid;
            prev_xfer  = xfer;
        end
    end

    // mode 0: ready always high, 1: random ready, 2: ready low for three cycles at the second address
    task automatic run_finite(input int unsigned s, input int unsigned n, input int mode);
        bit finished = 0;
        push_run(eff_step(s), n, 1);
        start = 1; step = 16'(s); num_samples = CW'(n);
        bus.addr_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        tick();
        start = 0;
        chk("start_latency_valid", 64'(bus.addr_valid), 64'(1));
        chk("start_latency_busy", 64'(busy), 64'(1));
        for (int i = 0; i < 600; i++) begin
            if (q.size() == 0 && pend == 0 && !busy) begin
                finished = 1;
                break;
            end
            if (mode == 1) begin
                bus.addr_ready = ($urandom_range(0, 3) != 0);
            end else if (mode == 2) begin
                if (i == 4) begin
                    chk("stall_hold_addr", 64'(bus.address), 64'(75));
                    chk("stall_hold_valid", 64'(bus.addr_valid), 64'(1));
                end
                bus.addr_ready = !(i >= 1 && i <= 3);
            end else begin
                bus.addr_ready = 1;
            end
            tick();
        end
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL run_timeout: step=%0d num=%0d left=%0d", s, n, q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; start = 0; stop = 0; step = '0; num_samples = '0;
        bus.addr_ready = 0;
        #1 rst = 1;
        repeat (2) tick();
        chk("reset_address", 64'(bus.address), 64'(0));
        chk("reset_valid", 64'(bus.addr_valid), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        rst = 0;
        tick();

        run_finite(1, 5, 0);
        run_finite(75, 6, 0);
        run_finite(75, 4, 2);
        run_finite(400, 3, 0);

        // start together with stop in IDLE must be ignored
        start = 1; stop = 1; step = 16'd10; num_samples = CW'(3);
        tick();
        start = 0; stop = 0;
        chk("start_stop_valid", 64'(bus.addr_valid), 64'(0));
        chk("start_stop_busy", 64'(busy), 64'(0));
        repeat (3) tick();
        chk("start_stop_still_idle", 64'(busy), 64'(0));

        // continuous mode, stopped with a transfer in the stop cycle
        push_run(7, 80, 0);
        pops = 0;
        start = 1; step = 16'd7; num_samples = '0; bus.addr_ready = 1;
        tick();
        start = 0;
        for (int i = 0; i < 200 && pops < 50; i++) tick();
        chk("cont_progress", 64'(pops >= 50), 64'(1));
        stop = 1;
        tick();
        stop = 0;
        chk("stop_valid", 64'(bus.addr_valid), 64'(0));
        chk("stop_busy", 64'(busy), 64'(0));
        chk("stop_addr_hold", 64'(bus.address), 64'(last_pop_addr));
        repeat (3) tick();
        q.delete();

        for (int r = 0; r < 8; r++) begin
            run_finite($urandom_range(0, 450), $urandom_range(1, 20), 1);
            tick();
        end

        // asynchronous reset in the middle of a run
        push_run(13, 40, 0);
        start = 1; step = 16'd13; num_samples = '0; bus.addr_ready = 1;
        tick();
        start = 0;
        repeat (6) tick();
        @(posedge clk);
        #3 rst = 1;
        #1;
        chk("async_rst_address", 64'(bus.address), 64'(0));
        chk("async_rst_valid", 64'(bus.addr_valid), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_done", 64'(done), 64'(0));
        chk("async_rst_wrap", 64'(bus.wrap), 64'(0));
        q.delete();
        repeat (2) tick();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_idle_valid", 64'(bus.addr_valid), 64'(0));
            chk("post_rst_idle_busy", 64'(busy), 64'(0));
        end

        run_finite(75, 6, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
